// File: rtl/fixed_div_seq_if.sv
// Handshake and operand/result bundle for the sequential fixed-point divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface fixed_div_seq_if #(
    parameter int WIDTH = 25
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] dividend;
    logic signed [WIDTH-1:0] divisor;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] quotient;
    logic                    overflow;
    logic                    div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_div_seq.sv
// Iterative signed fixed-point divider: quotient = round(dividend * 2^FRAC_BITS / divisor).
// Restoring division on magnitudes, one quotient bit per cycle, one extra bit for rounding,
// then sign restore with saturation. Fixed latency independent of operand values.
module fixed_div_seq #(
    parameter int WIDTH     = 25,
    parameter int FRAC_BITS = 14
) (
    input logic            clk,
    input logic            rstn,
    fixed_div_seq_if.slave bus
);
    localparam int N  = WIDTH + FRAC_BITS + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CNT   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic signed [WIDTH-1:0] quotient_r;
    logic                    overflow_r;
    logic                    div_by_zero_r;

    // Numerator bits leave at the MSB while quotient bits enter at the LSB, so after
    // N steps this register holds the full (unrounded) quotient magnitude.
    logic [N-1:0]            nq;
    // The stored remainder is always below |divisor| <= 2^(WIDTH-1), so WIDTH bits
    // suffice; the shifted trial value below is WIDTH+1 bits.
    logic [WIDTH-1:0]        rem;
    logic [WIDTH-1:0]        dvs_mag;
    logic                    sign;
    logic                    num_neg;
    logic                    num_zero;
    logic                    dvs_zero;

    logic [WIDTH:0]          rem_sh;
    logic [WIDTH:0]          diff;
    logic                    take;
    logic [WIDTH-1:0]        rem_nxt;
    logic                    accept;

    // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] neg_v;
        neg_v = $unsigned(-v);
        return v[WIDTH-1] ? neg_v : $unsigned(v);
    endfunction

    // Drop the half bit and round half away from zero on the magnitude.
    function automatic logic [N-1:0] round_mag(input logic [N-1:0] q);
        return (q >> 1) + {{(N-1){1'b0}}, q[0]};
    endfunction

    // Apply sign and clamp to the representable range; returns {quotient, overflow}.
    function automatic logic [WIDTH:0] saturate(input logic [N-1:0] mag, input logic neg);
        logic [N-1:0]     lim;
        logic [WIDTH-1:0] low;
        lim = neg ? {{(N-WIDTH){1'b0}}, MIN_NEG} : {{(N-WIDTH){1'b0}}, MAX_POS};
        low = mag[WIDTH-1:0];
        if (mag > lim)
            return {(neg ? MIN_NEG : MAX_POS), 1'b1};
        else if (neg)
            return {-low, 1'b0};
        else
            return {low, 1'b0};
    endfunction

    assign accept = (state == IDLE) && bus.in_valid;

    // Trial subtraction for one restoring step; the borrow bit decides the quotient bit.
    always_comb begin
        rem_sh  = {rem, nq[N-1]};
        diff    = rem_sh - {1'b0, dvs_mag};
        take    = ~diff[WIDTH];
        rem_nxt = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

    // Datapath registers: operand capture on accept, one shift/subtract per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            num_neg  <= bus.dividend[WIDTH-1];
            num_zero <= (bus.dividend == '0);
            dvs_zero <= (bus.divisor == '0);
            dvs_mag  <= abs_mag(bus.divisor);
            nq       <= {abs_mag(bus.dividend), {(FRAC_BITS+1){1'b0}}};
            rem      <= '0;
        end else if (state == CALC) begin
            nq  <= {nq[N-2:0], take};
            rem <= rem_nxt;
        end
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            quotient_r    <= '0;
            overflow_r    <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt        <= N_CNT;
                        in_ready_r <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_ONE)
                        state <= FINISH;
                end
                FINISH: begin
                    if (dvs_zero) begin
                        quotient_r    <= num_zero ? '0 : (num_neg ? MIN_NEG : MAX_POS);
                        overflow_r    <= 1'b0;
                        div_by_zero_r <= 1'b1;
                    end else begin
                        {quotient_r, overflow_r} <= saturate(round_mag(nq), sign);
                        div_by_zero_r            <= 1'b0;
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = quotient_r;
    assign bus.overflow    = overflow_r;
    assign bus.div_by_zero = div_by_zero_r;
endmodule

// File: tb/tb_fixed_div_seq.sv
// Self-checking bench for fixed_div_seq: table of directed vectors, random vectors
// against a behavioural model, output back-pressure and asynchronous reset mid-operation.
module tb_fixed_div_seq;
    localparam int W   = 25;
    localparam int F   = 14;
    localparam int LAT = W + F + 2;
    localparam int LAT_LIMIT = 200;
    localparam int MAXP = 16777215;
    localparam int MINN = -16777216;

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic signed [W-1:0] q;
        logic                o;
        logic                z;
    } vec_t;

    typedef struct {
        logic signed [W-1:0] q;
        logic                o;
        logic                z;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    vec_t vt[17];

    fixed_div_seq_if #(.WIDTH(W)) bus ();

    fixed_div_seq #(.WIDTH(W), .FRAC_BITS(F)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int q, input bit o, input bit z);
        vec_t v;
        v.a = W'(a);
        v.b = W'(b);
        v.q = W'(q);
        v.o = o;
        v.z = z;
        return v;
    endfunction

    // Reference: exact integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t   e;
        longint aa, bb, qq, mag;
        bit     neg;
        aa = a;
        bb = b;
        e.o = 1'b0;
        e.z = 1'b0;
        if (bb == 0) begin
            e.z = 1'b1;
            e.q = (aa > 0) ? W'(MAXP) : ((aa < 0) ? W'(MINN) : '0);
            return e;
        end
        neg = (aa < 0) != (bb < 0);
        if (aa < 0) aa = -aa;
        if (bb < 0) bb = -bb;
        qq  = (aa * (64'sd1 <<< (F + 1))) / bb;
        mag = (qq + 1) / 2;
        if (neg && mag > 64'sd16777216) begin
            e.q = W'(MINN);
            e.o = 1'b1;
        end else if (!neg && mag > 64'sd16777215) begin
            e.q = W'(MAXP);
            e.o = 1'b1;
        end else begin
            e.q = neg ? W'(-mag) : W'(mag);
        end
        return e;
    endfunction

    // Drive one operation, check latency, result and handshake behaviour.
    task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                          input exp_t ex, input int hold, input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        chk({tag, " in_ready idle"}, longint'(bus.in_ready), 1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        sb.push_back(ex);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        chk({tag, " in_ready busy"}, longint'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < LAT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, LAT);
        if (!bus.out_valid) begin
            sb.delete();
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, " quotient"}, bus.quotient, e.q);
        chk({tag, " overflow"}, longint'(bus.overflow), longint'(e.o));
        chk({tag, " div_by_zero"}, longint'(bus.div_by_zero), longint'(e.z));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.dividend = W'(i * 1000 + 7);
            bus.divisor  = W'(3);
            @(negedge clk);
            chk({tag, " hold out_valid"}, longint'(bus.out_valid), 1);
            chk({tag, " hold quotient"}, bus.quotient, e.q);
            chk({tag, " hold in_ready"}, longint'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " out_valid drop"}, longint'(bus.out_valid), 0);
        chk({tag, " in_ready back"}, longint'(bus.in_ready), 1);
        chk({tag, " quotient kept"}, bus.quotient, e.q);
    endtask

    initial begin
        exp_t                ex;
        logic signed [W-1:0] ra, rb;

        n_checks = 0;
        n_fail   = 0;
        vt[0]  = mk(49152, 32768, 24576, 0, 0);
        vt[1]  = mk(-122880, 40960, -49152, 0, 0);
        vt[2]  = mk(122880, -40960, -49152, 0, 0);
        vt[3]  = mk(-122880, -40960, 49152, 0, 0);
        vt[4]  = mk(1, 49152, 0, 0, 0);
        vt[5]  = mk(1, 32768, 1, 0, 0);
        vt[6]  = mk(-1, 32768, -1, 0, 0);
        vt[7]  = mk(3, 65536, 1, 0, 0);
        vt[8]  = mk(16384000, 1, MAXP, 1, 0);
        vt[9]  = mk(-16384000, 1, MINN, 1, 0);
        vt[10] = mk(MINN, 16384, MINN, 0, 0);
        vt[11] = mk(MAXP, 16384, MAXP, 0, 0);
        vt[12] = mk(-1, -32768, 1, 0, 0);
        vt[13] = mk(0, 5, 0, 0, 0);
        vt[14] = mk(81920, 0, MAXP, 0, 1);
        vt[15] = mk(0, 0, 0, 0, 1);
        vt[16] = mk(-81920, 0, MINN, 0, 1);

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        chk("reset in_ready", longint'(bus.in_ready), 1);
        chk("reset out_valid", longint'(bus.out_valid), 0);
        chk("reset quotient", bus.quotient, 0);
        chk("reset overflow", longint'(bus.overflow), 0);
        chk("reset div_by_zero", longint'(bus.div_by_zero), 0);
        rstn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            ex.q = vt[i].q;
            ex.o = vt[i].o;
            ex.z = vt[i].z;
            run_op(vt[i].a, vt[i].b, ex, (i == 1) ? 20 : 0, $sformatf("vec%0d", i));
        end

        // Reset while an operation is in CALC; the previous result is nonzero with div_by_zero set.
        @(negedge clk);
        bus.dividend = W'(49152);
        bus.divisor  = W'(32768);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("midcalc in_ready", longint'(bus.in_ready), 0);
        #2 rstn = 1'b0;
        #1;
        chk("async in_ready", longint'(bus.in_ready), 1);
        chk("async out_valid", longint'(bus.out_valid), 0);
        chk("async quotient", bus.quotient, 0);
        chk("async overflow", longint'(bus.overflow), 0);
        chk("async div_by_zero", longint'(bus.div_by_zero), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        chk("discarded op out_valid", longint'(bus.out_valid), 0);
        ex.q = W'(24576);
        ex.o = 1'b0;
        ex.z = 1'b0;
        run_op(W'(49152), W'(32768), ex, 0, "after reset");

        for (int i = 0; i < 10; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rb = rb >>> $urandom_range(0, 22);
            run_op(ra, rb, model(ra, rb), i % 3, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
